// File: rtl/e21_lint_sync_claim_pkg.sv
// Shared constants and types for the local interrupt input stage.
// Defaults here size the top-level parameters and the claim index type.
package e21_lint_sync_claim_pkg;

   localparam int E21_LINT_NUM_IRQ     = 2;
   localparam int E21_LINT_SYNC_STAGES = 2;
   localparam int E21_LINT_IDX_W       = (E21_LINT_NUM_IRQ > 1) ? $clog2(E21_LINT_NUM_IRQ) : 1;

   typedef enum logic {
      IRQ_LEVEL = 1'b0,
      IRQ_EDGE  = 1'b1
   } irq_mode_e;

   typedef logic [E21_LINT_IDX_W-1:0] claim_id_t;

endpackage

// File: rtl/e21_sync_chain.sv
// Single-bit multi-flop synchroniser; the only crossing point for the raw irq lines,
// so any metastability waiver belongs on sync_q here and nowhere else.
module e21_sync_chain #(
   parameter int DEPTH = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] sync_q;

   always_ff @(posedge clock) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[DEPTH-2:0], d_i};
   end

   assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/e21_lint_sync_claim.sv
// Local interrupt input stage: synchronise, detect edge/level, hold pending bits,
// and offer the lowest pending enabled line through a lockable valid/ready claim.
module e21_lint_sync_claim
   import e21_lint_sync_claim_pkg::*;
#(
   parameter  int NUM_IRQ     = E21_LINT_NUM_IRQ,
   parameter  int SYNC_STAGES = E21_LINT_SYNC_STAGES,
   localparam int IDX_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_async,
   input  logic [NUM_IRQ-1:0] irq_edge_mode,
   input  logic [NUM_IRQ-1:0] irq_enable,
   output logic [NUM_IRQ-1:0] irq_pending,
   output logic               irq_any,
   output logic               claim_valid,
   output logic [IDX_W-1:0]   claim_id,
   input  logic               claim_ready,
   output logic [NUM_IRQ-1:0] overrun,
   input  logic               overrun_clr
);

   localparam int ARM_W = $clog2(SYNC_STAGES + 2);

   logic [NUM_IRQ-1:0] sync_s;
   logic [NUM_IRQ-1:0] prev_q;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] ovr_q, ovr_d;
   logic [NUM_IRQ-1:0] edge_det;
   logic [NUM_IRQ-1:0] avail;
   logic [NUM_IRQ-1:0] claim_hit;
   logic [ARM_W-1:0]   arm_q;
   logic               lock_q;
   logic [IDX_W-1:0]   lock_id_q;
   logic [IDX_W-1:0]   pick_id;
   logic               pick_vld;
   logic               hs;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
      e21_sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
         .clock   (clock),
         .reset_n (reset_n),
         .d_i     (irq_async[g]),
         .q_o     (sync_s[g])
      );
   end

   // Arm counter hides lines already high when reset releases from looking like edges.
   assign edge_det = sync_s & ~prev_q & {NUM_IRQ{arm_q == '0}};
   assign avail    = pend_q & irq_enable;

   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (avail[i]) begin
            pick_vld = 1'b1;
            pick_id  = IDX_W'(i);
         end
      end
   end

   assign claim_valid = lock_q | pick_vld;
   assign claim_id    = lock_q ? lock_id_q : pick_id;
   assign hs          = claim_valid & claim_ready;

   always_comb begin
      claim_hit = '0;
      pend_d    = pend_q;
      for (int i = 0; i < NUM_IRQ; i++) begin
         claim_hit[i] = hs && (claim_id == IDX_W'(i));
         if (irq_mode_e'(irq_edge_mode[i]) == IRQ_LEVEL) begin
            pend_d[i] = sync_s[i] & irq_enable[i];
         end else if (edge_det[i] && irq_enable[i]) begin
            pend_d[i] = 1'b1;
         end else if (claim_hit[i] || !irq_enable[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // A new overrun in the clearing cycle survives the clear.
   assign ovr_d = (ovr_q & ~{NUM_IRQ{overrun_clr}}) | (edge_det & pend_q & ~claim_hit);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         prev_q    <= '0;
         arm_q     <= ARM_W'(SYNC_STAGES + 1);
         pend_q    <= '0;
         ovr_q     <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         prev_q <= sync_s;
         if (arm_q != '0) arm_q <= arm_q - ARM_W'(1);
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
         if (hs)               lock_q <= 1'b0;
         else if (claim_valid) lock_q <= 1'b1;
         if (claim_valid && !claim_ready) lock_id_q <= claim_id;
      end
   end

   assign irq_pending = pend_q;
   assign irq_any     = |pend_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_e21_lint_sync_claim.sv
// Directed bench for the local interrupt input stage: arm masking, latency,
// claim lock/priority, edge-vs-claim collision, overrun, level mode and reset.
module tb_e21_lint_sync_claim;

   logic       clock;
   logic       reset_n;
   logic [1:0] irq_async;
   logic [1:0] irq_edge_mode;
   logic [1:0] irq_enable;
   logic [1:0] irq_pending;
   logic       irq_any;
   logic       claim_valid;
   logic [0:0] claim_id;
   logic       claim_ready;
   logic [1:0] overrun;
   logic       overrun_clr;

   int n_tests = 0;
   int n_fail  = 0;

   e21_lint_sync_claim #(.NUM_IRQ(2), .SYNC_STAGES(2)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .irq_async     (irq_async),
      .irq_edge_mode (irq_edge_mode),
      .irq_enable    (irq_enable),
      .irq_pending   (irq_pending),
      .irq_any       (irq_any),
      .claim_valid   (claim_valid),
      .claim_id      (claim_id),
      .claim_ready   (claim_ready),
      .overrun       (overrun),
      .overrun_clr   (overrun_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      irq_async     = 2'b11;
      irq_edge_mode = 2'b11;
      irq_enable    = 2'b11;
      claim_ready   = 1'b0;
      overrun_clr   = 1'b0;
      repeat (3) tick();
      chk2("rst_pending", irq_pending, 2'b00);
      chk1("rst_valid",   claim_valid, 1'b0);
      chk1("rst_id",      claim_id,    1'b0);
      chk1("rst_any",     irq_any,     1'b0);
      chk2("rst_overrun", overrun,     2'b00);

      // Lines high across reset release must not register as edges.
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk2("arm_mask_pending", irq_pending, 2'b00);
      end

      // Drop and re-raise line 0; pending appears on the third edge after the rise.
      irq_async = 2'b10;
      repeat (4) tick();
      irq_async = 2'b11;
      tick(); chk2("lat_e1", irq_pending, 2'b00);
      tick(); chk2("lat_e2", irq_pending, 2'b00);
      tick(); chk2("lat_e3", irq_pending, 2'b01);
      chk1("lat_valid", claim_valid, 1'b1);
      chk1("lat_id",    claim_id,    1'b0);
      chk1("lat_any",   irq_any,     1'b1);
      claim_ready = 1'b1;
      tick(); chk2("lat_claimed", irq_pending, 2'b00);
      claim_ready = 1'b0;

      // Simultaneous pulses on both lines, held claim, then two accepts.
      irq_async = 2'b00;
      repeat (3) tick();
      irq_async = 2'b11;
      tick();
      irq_async = 2'b00;
      tick(); tick();
      chk2("both_pending", irq_pending, 2'b11);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk1("both_hold_valid", claim_valid, 1'b1);
         chk1("both_hold_id",    claim_id,    1'b0);
      end
      claim_ready = 1'b1;
      tick();
      chk2("both_acc0_pending", irq_pending, 2'b10);
      chk1("both_acc0_id",      claim_id,    1'b1);
      tick();
      chk2("both_acc1_pending", irq_pending, 2'b00);
      chk1("both_acc1_valid",   claim_valid, 1'b0);
      claim_ready = 1'b0;

      // Line 1 locked; a lower line arriving later must not steal the offer.
      irq_async = 2'b10;
      tick();
      irq_async = 2'b00;
      tick(); tick();
      chk1("lock_id1_initial", claim_id, 1'b1);
      tick();
      irq_async = 2'b01;
      tick();
      irq_async = 2'b00;
      tick(); tick();
      chk2("lock_pending", irq_pending, 2'b11);
      chk1("lock_id_held", claim_id,    1'b1);
      chk1("lock_valid",   claim_valid, 1'b1);
      claim_ready = 1'b1;
      tick();
      chk2("lock_after_hs_pending", irq_pending, 2'b01);
      chk1("lock_after_hs_id",      claim_id,    1'b0);
      tick();
      chk2("lock_drain", irq_pending, 2'b00);
      claim_ready = 1'b0;

      // Edge colliding with its own claim keeps the line pending, no overrun.
      irq_async = 2'b01;
      tick();
      irq_async = 2'b00;
      tick(); tick();
      chk2("coll_first", irq_pending, 2'b01);
      irq_async = 2'b01;
      tick();
      irq_async = 2'b00;
      tick();
      claim_ready = 1'b1;
      tick();
      chk2("coll_pending", irq_pending, 2'b01);
      chk2("coll_overrun", overrun,     2'b00);
      claim_ready = 1'b0;
      irq_async = 2'b01;
      tick();
      irq_async = 2'b00;
      tick(); tick();
      chk2("ovr_set",     overrun,     2'b01);
      chk2("ovr_pending", irq_pending, 2'b01);
      tick();
      chk2("ovr_sticky", overrun, 2'b01);
      overrun_clr = 1'b1;
      tick();
      chk2("ovr_cleared", overrun, 2'b00);
      overrun_clr = 1'b0;
      claim_ready = 1'b1;
      tick();
      chk2("ovr_drain", irq_pending, 2'b00);
      claim_ready = 1'b0;

      // Line 1 in level mode follows its enable one cycle late; accept is a no-op.
      irq_edge_mode = 2'b01;
      irq_async     = 2'b10;
      repeat (3) tick();
      chk2("lvl_on", irq_pending, 2'b10);
      irq_enable = 2'b01;
      tick();
      chk2("lvl_en_off", irq_pending, 2'b00);
      irq_enable = 2'b11;
      tick();
      chk2("lvl_en_on", irq_pending, 2'b10);
      claim_ready = 1'b1;
      tick();
      chk2("lvl_after_hs", irq_pending, 2'b10);
      claim_ready = 1'b0;
      tick();
      chk1("lvl_locked_valid", claim_valid, 1'b1);

      // Reset while locked drops everything and re-arms edge masking.
      reset_n       = 1'b0;
      irq_edge_mode = 2'b11;
      tick();
      reset_n = 1'b1;
      chk1("mid_rst_valid",   claim_valid, 1'b0);
      chk2("mid_rst_pending", irq_pending, 2'b00);
      chk2("mid_rst_overrun", overrun,     2'b00);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk2("mid_rst_arm_mask", irq_pending, 2'b00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/e21_lint_sync_claim.md
Name: e21_lint_sync_claim

Overview:
- Input stage for the core's local interrupt lines. Synchronises NUM_IRQ asynchronous interrupt inputs into the core clock domain and detects edges or levels per line.
- Holds a pending bit per line and offers the lowest-index pending line through a valid/ready claim handshake.
- Its irq_pending vector feeds the downstream pass-through wiring stage, which forwards interrupt bits unchanged into the core.

Parameters:
- NUM_IRQ, 2, number of interrupt lines.
- SYNC_STAGES, 2, synchroniser depth in flops; legal range 2..4.
- IDX_W, $clog2(NUM_IRQ) (minimum 1), width of claim_id. Derived; never overridden.

Ports:
- clock  input  1  core clock; all state updates on the rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- irq_async  input  NUM_IRQ  raw asynchronous interrupt lines.
- irq_edge_mode  input  NUM_IRQ  per line: 1 = rising-edge triggered, 0 = level. Quasi-static.
- irq_enable  input  NUM_IRQ  per-line enable.
- irq_pending  output  NUM_IRQ  registered pending vector.
- irq_any  output  1  OR-reduction of irq_pending.
- claim_valid  output  1  a pending line is offered for claim.
- claim_id  output  IDX_W  index of the offered line.
- claim_ready  input  1  consumer accepts the offered claim.
- overrun  output  NUM_IRQ  sticky: an edge arrived while that line was already pending.
- overrun_clr  input  1  clears all overrun bits.

Behaviour:
- Reset (reset_n low at a clock edge):
  - Sync chain, edge-history flop, irq_pending, overrun and claim lock all go to 0, so every output is 0.
  - The arm counter loads SYNC_STAGES+1.
- Arm counter:
  - Decrements once per cycle after reset release and saturates at 0.
  - While it is non-zero, edge detection is masked. A line already high at reset release is therefore not seen as an edge.
  - Level lines are not masked.
- Synchroniser:
  - s[i] is the last flop of the SYNC_STAGES chain.
  - Edge detect is s[i] & ~prev[i], with prev registered from s[i].
- Latency:
  - An input rising at edge k produces s at edge k+SYNC_STAGES and irq_pending at edge k+SYNC_STAGES+1, in both modes.
- Level line: irq_pending[i] <= s[i] & irq_enable[i]. A claim handshake does not clear it.
- Edge line, evaluated per cycle, in priority order:
  1. Set if a detected edge coincides with enable.
  2. Otherwise clear on a claim handshake of that line.
  3. Otherwise clear if enable is low.
  4. Otherwise hold.
  - An edge in the same cycle as a claim of the same line keeps it pending (edge wins).
- Overrun:
  - overrun[i] sets when a detected edge finds irq_pending[i] already 1 and no claim of line i in that cycle.
  - overrun_clr clears all bits. A set and a clear in the same cycle leaves the bit set.
- Claim handshake:
  - When unlocked: claim_valid = |(irq_pending & irq_enable), and claim_id = lowest such index.
  - With claim_valid high and claim_ready low, lock and hold claim_id stable on following cycles, even if a lower index becomes pending or enable drops.
  - Lock releases on the handshake (claim_valid & claim_ready).
  - A locked level line whose level drops stays valid until accepted; the accept is then a no-op.
- Back-to-back: a handshake in cycle n means the next claim reflects updated pending in cycle n+1, so there is at most one handshake per cycle.
- Reset mid-operation: the lock is dropped and all pending state is lost. No handshake is implied.

Decomposition:
- Shared package holds:
  - constants E21_LINT_NUM_IRQ = 2 and E21_LINT_SYNC_STAGES = 2;
  - typedef irq_mode_e {IRQ_LEVEL = 0, IRQ_EDGE = 1};
  - typedef for the claim_id width.
- One sub-module: e21_sync_chain.
  - Parameterised depth, single-bit, synchronous active-low reset to 0.
  - Instantiated per line; the only place where a metastability waiver applies.

Test Plan:
- Reset release with irq_async = 2'b11, edge mode, enable = 2'b11 → no pending bits at any cycle. Then drop and re-raise line 0 → irq_pending = 2'b01 exactly SYNC_STAGES+1 = 3 edges after the rise.
- Both lines edge, pulse both in the same cycle, claim_ready low for 4 cycles → claim_valid = 1 and claim_id = 0 held throughout. Then ready = 1 for two cycles → ids 0 then 1 accepted, irq_pending returns to 0.
- Line 1 alone pending and locked with ready low; line 0 then becomes pending → claim_id stays 1 until the handshake, then becomes 0 the next cycle.
- Edge on line 0 in the same cycle as its claim handshake → irq_pending[0] stays 1 and overrun[0] stays 0. A further edge while pending with no claim → overrun[0] = 1 until overrun_clr.
- Line 1 level mode, held high, enable toggled 1→0→1 → irq_pending[1] follows enable with a 1-cycle delay. A handshake does not clear it.
- Assert reset_n low for one cycle while a claim is locked → the next cycle has claim_valid = 0, irq_pending = 0, overrun = 0, and the arm counter reloads.
